// File: rtl/bfly_operand_feeder.sv
// bfly_operand_feeder: captures one N-point complex frame into a register
// buffer, then issues the N/2 butterfly operand pairs of one stage with the
// matching twiddle ROM index over a valid/ready handshake.
// Optional feature macro: BFLY_OPERAND_FEEDER_BITREV_EN (bit-reversed load order).
module bfly_operand_feeder #(
  parameter int unsigned BITS  = 16,
  parameter int unsigned N     = 16,
  parameter int unsigned LOG2N = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LOG2N-1:0] stage,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BITS-1:0]  in_r,
  input  logic [BITS-1:0]  in_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BITS-1:0]  in1_r,
  output logic [BITS-1:0]  in1_i,
  output logic [BITS-1:0]  in2_r,
  output logic [BITS-1:0]  in2_i,
  output logic [LOG2N-2:0] tw_idx,
  output logic             busy,
  output logic             done
);

  localparam int unsigned IW = LOG2N;
  localparam int unsigned PW = LOG2N - 1;
  localparam int unsigned DW = 2 * BITS;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;

  logic [1:0]    state, state_n;
  logic [IW-1:0] stage_q, stage_n;
  logic [IW-1:0] wr_cnt, wr_cnt_n;
  logic [PW-1:0] pair_cnt, pair_n;
  logic          done_n;
  logic [IW-1:0] idx1_q, idx2_q;
  logic [IW-1:0] span_c, j_c, g_c, idx1_c, idx2_c;
  logic [PW-1:0] tw_c;
  logic [IW-1:0] wa;
  logic [DW-1:0] mem [N];

`ifdef BFLY_OPERAND_FEEDER_BITREV_EN
  function automatic logic [IW-1:0] bitrev(input logic [IW-1:0] a);
    logic [IW-1:0] r;
    r = '0;
    for (int b = 0; b < int'(IW); b++) r[b] = a[int'(IW) - 1 - b];
    return r;
  endfunction

  assign wa = bitrev(wr_cnt);
`else
  assign wa = wr_cnt;
`endif

  // Next-state, counter and done-pulse decision
  always_comb begin
    state_n  = state;
    stage_n  = stage_q;
    wr_cnt_n = wr_cnt;
    pair_n   = pair_cnt;
    done_n   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n  = S_LOAD;
          stage_n  = (stage > IW'(LOG2N - 1)) ? IW'(LOG2N - 1) : stage;
          wr_cnt_n = '0;
          pair_n   = '0;
        end
      end
      S_LOAD: begin
        if (in_valid && in_ready) begin
          wr_cnt_n = wr_cnt + 1'b1;
          if (wr_cnt == IW'(N - 1)) state_n = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (out_valid && out_ready) begin
          pair_n = pair_cnt + 1'b1;
          if (pair_cnt == PW'(N / 2 - 1)) begin
            state_n = S_IDLE;
            done_n  = 1'b1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Operand indices and twiddle index for the upcoming pair
  always_comb begin
    span_c = IW'(1) << stage_n;
    j_c    = IW'(pair_n) & (span_c - 1'b1);
    g_c    = IW'(pair_n) >> stage_n;
    idx1_c = (g_c << (stage_n + 1'b1)) | j_c;
    idx2_c = idx1_c | span_c;
    tw_c   = PW'(j_c << (IW'(LOG2N - 1) - stage_n));
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      stage_q   <= '0;
      wr_cnt    <= '0;
      pair_cnt  <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      tw_idx    <= '0;
      idx1_q    <= '0;
      idx2_q    <= '0;
    end else begin
      state     <= state_n;
      stage_q   <= stage_n;
      wr_cnt    <= wr_cnt_n;
      pair_cnt  <= pair_n;
      in_ready  <= (state_n == S_LOAD);
      out_valid <= (state_n == S_ISSUE);
      busy      <= (state_n != S_IDLE);
      done      <= done_n;
      tw_idx    <= tw_c;
      idx1_q    <= idx1_c;
      idx2_q    <= idx2_c;
    end
  end

  // Frame buffer write; contents survive reset
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) mem[wa] <= {in_r, in_i};
  end

  assign in1_r = mem[idx1_q][DW-1:BITS];
  assign in1_i = mem[idx1_q][BITS-1:0];
  assign in2_r = mem[idx2_q][DW-1:BITS];
  assign in2_i = mem[idx2_q][BITS-1:0];

endmodule

// File: tb/tb_bfly_operand_feeder.sv
// Self-checking bench for bfly_operand_feeder (N=16). Honours
// BFLY_OPERAND_FEEDER_BITREV_EN in its reference model when defined.
module tb_bfly_operand_feeder;

  localparam int unsigned BITS  = 16;
  localparam int unsigned N     = 16;
  localparam int unsigned LOG2N = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [LOG2N-1:0] stage;
  logic             in_valid;
  logic             in_ready;
  logic [BITS-1:0]  in_r, in_i;
  logic             out_valid;
  logic             out_ready;
  logic [BITS-1:0]  in1_r, in1_i, in2_r, in2_i;
  logic [LOG2N-2:0] tw_idx;
  logic             busy;
  logic             done;

  int n_err  = 0;
  int n_chk  = 0;
  int last_cycles = 0;

  logic [BITS-1:0] ref_r [N];
  logic [BITS-1:0] ref_i [N];
  logic [BITS-1:0] cap1r [N/2];
  logic [BITS-1:0] cap1i [N/2];
  logic [BITS-1:0] cap2r [N/2];
  logic [31:0]     capw  [N/2];

`ifdef BFLY_OPERAND_FEEDER_BITREV_EN
  localparam logic [15:0] S0P1_IN1 = 16'd4,  S0P1_IN2 = 16'd12;
  localparam logic [15:0] S0P0_IN2 = 16'd8;
  localparam logic [15:0] S1P3_IN1 = 16'd10, S1P3_IN2 = 16'd14;
  localparam logic [15:0] S3P3_IN1 = 16'd12, S3P3_IN2 = 16'd13, S3P3_IN1I = 16'hfff4;
`else
  localparam logic [15:0] S0P1_IN1 = 16'd2,  S0P1_IN2 = 16'd3;
  localparam logic [15:0] S0P0_IN2 = 16'd1;
  localparam logic [15:0] S1P3_IN1 = 16'd5,  S1P3_IN2 = 16'd7;
  localparam logic [15:0] S3P3_IN1 = 16'd3,  S3P3_IN2 = 16'd11, S3P3_IN1I = 16'hfffd;
`endif

  bfly_operand_feeder #(.BITS(BITS), .N(N), .LOG2N(LOG2N)) dut (
    .clk(clk), .rst(rst), .start(start), .stage(stage),
    .in_valid(in_valid), .in_ready(in_ready), .in_r(in_r), .in_i(in_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .in1_r(in1_r), .in1_i(in1_i), .in2_r(in2_r), .in2_i(in2_i),
    .tw_idx(tw_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Buffer address of the n-th streamed sample
  function automatic int model_wa(input int n);
`ifdef BFLY_OPERAND_FEEDER_BITREV_EN
    int r;
    r = 0;
    for (int b = 0; b < int'(LOG2N); b++)
      if (((n >> b) & 1) == 1) r = r + (1 << (int'(LOG2N) - 1 - b));
    return r;
`else
    return n;
`endif
  endfunction

  // One full frame: start, stream N samples, consume N/2 pairs, check done
  task automatic run_frame(input int stg, input int vpct, input int rpct, input bit rnd);
    int eff, span, n, k, j, g, i1, i2, tw, cyc, guard;
    logic [BITS-1:0] dr, di;
    eff  = (stg > int'(LOG2N) - 1) ? int'(LOG2N) - 1 : stg;
    span = 1 << eff;
    start = 1'b1; stage = LOG2N'(stg); in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; cyc = 1;
    check_eq("busy_after_start", 32'(busy), 32'd1);
    check_eq("in_ready_after_start", 32'(in_ready), 32'd1);
    n = 0; guard = 0;
    while (n < int'(N) && guard < 500) begin
      check_eq("load_in_ready", 32'(in_ready), 32'd1);
      check_eq("load_out_valid", 32'(out_valid), 32'd0);
      in_valid = ($urandom_range(0, 99) < vpct);
      dr = rnd ? BITS'($urandom) : BITS'(n);
      di = rnd ? BITS'($urandom) : BITS'(-n);
      in_r = dr; in_i = di;
      start = ($urandom_range(0, 3) == 0);
      stage = LOG2N'($urandom_range(0, 15));
      @(posedge clk); #1;
      cyc++; guard++;
      if (in_valid) begin
        ref_r[model_wa(n)] = dr;
        ref_i[model_wa(n)] = di;
        n++;
      end
    end
    in_valid = 1'b0; start = 1'b0;
    check_eq("load_count", 32'(n), 32'(N));
    if (n < int'(N)) return;
    check_eq("issue_in_ready", 32'(in_ready), 32'd0);
    k = 0; guard = 0;
    while (k < int'(N) / 2 && guard < 500) begin
      j  = k % span;
      g  = k / span;
      i1 = 2 * span * g + j;
      i2 = i1 + span;
      tw = (j * (int'(N) / (2 * span))) % (int'(N) / 2);
      check_eq("issue_out_valid", 32'(out_valid), 32'd1);
      check_eq("issue_busy", 32'(busy), 32'd1);
      check_eq("issue_done", 32'(done), 32'd0);
      check_eq("in1_r", 32'(in1_r), 32'(ref_r[i1]));
      check_eq("in1_i", 32'(in1_i), 32'(ref_i[i1]));
      check_eq("in2_r", 32'(in2_r), 32'(ref_r[i2]));
      check_eq("in2_i", 32'(in2_i), 32'(ref_i[i2]));
      check_eq("tw_idx", 32'(tw_idx), 32'(tw));
      out_ready = ($urandom_range(0, 99) < rpct);
      in_valid  = ($urandom_range(0, 1) == 1);
      start     = ($urandom_range(0, 3) == 0);
      if (out_ready) begin
        cap1r[k] = in1_r; cap1i[k] = in1_i; cap2r[k] = in2_r; capw[k] = 32'(tw_idx);
      end
      @(posedge clk); #1;
      cyc++; guard++;
      if (out_ready) k++;
    end
    out_ready = 1'b0; in_valid = 1'b0; start = 1'b0;
    check_eq("pair_count", 32'(k), 32'(N / 2));
    check_eq("done_pulse", 32'(done), 32'd1);
    check_eq("done_busy", 32'(busy), 32'd0);
    check_eq("done_out_valid", 32'(out_valid), 32'd0);
    check_eq("done_in_ready", 32'(in_ready), 32'd0);
    last_cycles = cyc;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; stage = '0; in_valid = 1'b0;
    in_r = '0; in_i = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_tw_idx", 32'(tw_idx), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Stage 0, full throughput; next frames start in the done cycle
    run_frame(0, 100, 100, 1'b0);
    check_eq("min_frame_cycles", 32'(last_cycles), 32'(1 + N + N / 2));
    check_eq("s0_p0_in1_r", 32'(cap1r[0]), 32'd0);
    check_eq("s0_p0_in2_r", 32'(cap2r[0]), 32'(S0P0_IN2));
    check_eq("s0_p0_tw", capw[0], 32'd0);
    check_eq("s0_p1_in1_r", 32'(cap1r[1]), 32'(S0P1_IN1));
    check_eq("s0_p1_in2_r", 32'(cap2r[1]), 32'(S0P1_IN2));
    check_eq("s0_p1_tw", capw[1], 32'd0);

    run_frame(1, 100, 100, 1'b0);
    check_eq("s1_p3_in1_r", 32'(cap1r[3]), 32'(S1P3_IN1));
    check_eq("s1_p3_in2_r", 32'(cap2r[3]), 32'(S1P3_IN2));
    check_eq("s1_p3_tw", capw[3], 32'd4);

    run_frame(3, 100, 100, 1'b0);
    check_eq("s3_p3_in1_r", 32'(cap1r[3]), 32'(S3P3_IN1));
    check_eq("s3_p3_in1_i", 32'(cap1i[3]), 32'(S3P3_IN1I));
    check_eq("s3_p3_in2_r", 32'(cap2r[3]), 32'(S3P3_IN2));
    check_eq("s3_p3_tw", capw[3], 32'd3);

    run_frame(7, 100, 100, 1'b0);
    check_eq("s7_p3_in1_r", 32'(cap1r[3]), 32'(S3P3_IN1));
    check_eq("s7_p3_in2_r", 32'(cap2r[3]), 32'(S3P3_IN2));
    check_eq("s7_p3_tw", capw[3], 32'd3);
    @(posedge clk); #1;
    check_eq("done_one_cycle", 32'(done), 32'd0);

    // Reset in the middle of ISSUE aborts the frame
    start = 1'b1; stage = 4'd2;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1;
    for (int n = 0; n < int'(N); n++) begin
      in_r = BITS'(n); in_i = BITS'(-n);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("mid_issue_out_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b0;
    check_eq("abort_out_valid", 32'(out_valid), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_in_ready", 32'(in_ready), 32'd0);
    check_eq("abort_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    check_eq("abort_no_done", 32'(done), 32'd0);

    run_frame(2, 100, 100, 1'b0);

    // Handshake stress with random data, stages and gaps
    for (int f = 0; f < 20; f++) begin
      run_frame(int'($urandom_range(0, 15)), 60, 55, 1'b1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
